// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus Avalon-MM memory slave.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } bus_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [3:0]  BE_WORD      = 4'b1111;

endpackage

// File: rtl/mips_ram_bank.sv
// Word-organised RAM with byte-lane writes on posedge and an asynchronous read port,
// so the decoded word is ready on the same edge that moves the slave into ACK.
module mips_ram_bank #(
    parameter  int WORDS = 1024,
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mips_avalon_ram.sv
// Avalon-MM slave serving instruction (at the reset vector) and data (at 0) banks with
// programmable wait states. Define BUS_TRACE_EN for a simulation-only per-access trace.
module mips_avalon_ram
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] INSTR_BASE  = RESET_VECTOR,
    parameter int          INSTR_WORDS = 1024,
    parameter int          DATA_WORDS  = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int          IAW          = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
    localparam int          DAW          = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [29:0] INSTR_BASE_W = INSTR_BASE[31:2];
    localparam logic [29:0] INSTR_END_W  = INSTR_BASE_W + 30'(INSTR_WORDS);
    localparam logic [29:0] DATA_END_W   = 30'(DATA_WORDS);
    localparam logic [3:0]  WAIT_INIT    = 4'(WAIT_CYCLES);

    bus_state_t  state;
    bus_state_t  next_state;
    logic [3:0]  count;

    logic [29:0] lat_word;
    logic        lat_write;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic        lat_err;

    logic        request;
    logic        live_err;
    logic        live_write;
    logic [29:0] sel_word;
    logic        instr_hit;
    logic        data_hit;
    logic        acc_err;
    logic        acc_write;
    logic        enter_ack;
    logic [31:0] acc_rdata;
    logic [31:0] instr_rdata;
    logic [31:0] data_rdata;
    logic [IAW-1:0] instr_idx;
    logic [DAW-1:0] data_idx;
    logic        instr_we;
    logic        data_we;

    assign request     = read | write;
    assign waitrequest = request && (state != ACK);

    // In IDLE the live request is decoded so a zero-wait access can complete from it;
    // afterwards only the latched copy matters, whatever the CPU does to the bus.
    assign sel_word   = (state == IDLE) ? address[31:2] : lat_word;
    assign instr_hit  = (sel_word >= INSTR_BASE_W) && (sel_word < INSTR_END_W);
    assign data_hit   = (sel_word < DATA_END_W);
    assign instr_idx  = IAW'(sel_word - INSTR_BASE_W);
    assign data_idx   = DAW'(sel_word);

    assign live_write = write && !read;
    assign live_err   = (address[1:0] != 2'b00) || (read && write) || !(instr_hit || data_hit);
    assign acc_err    = (state == IDLE) ? live_err : lat_err;
    assign acc_write  = (state == IDLE) ? live_write : lat_write;

    assign acc_rdata  = instr_hit ? instr_rdata :
                        data_hit  ? data_rdata  : 32'h0;

    assign instr_we   = (state == ACK) && lat_write && instr_hit;
    assign data_we    = (state == ACK) && lat_write && data_hit;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (request) begin
                    next_state = (WAIT_CYCLES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (!request) begin
                    next_state = IDLE;
                end else if (count <= 4'd1) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign enter_ack = (next_state == ACK) && (state != ACK);

    // Read data and the sticky error are both captured on the edge that enters ACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            lat_word  <= 30'd0;
            lat_write <= 1'b0;
            lat_be    <= 4'd0;
            lat_wdata <= 32'd0;
            lat_err   <= 1'b0;
            readdata  <= 32'd0;
            bus_error <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && request) begin
                lat_word  <= address[31:2];
                lat_write <= live_write;
                lat_be    <= live_write ? byteenable : BE_WORD;
                lat_wdata <= writedata;
                lat_err   <= live_err;
                count     <= WAIT_INIT;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (enter_ack) begin
                if (!acc_write) begin
                    readdata <= acc_rdata;
                end
                if (acc_err) begin
                    bus_error <= 1'b1;
                end
            end
        end
    end

    mips_ram_bank #(
        .WORDS (INSTR_WORDS)
    ) u_instr_bank (
        .clk   (clk),
        .we    (instr_we),
        .be    (lat_be),
        .idx   (instr_idx),
        .wdata (lat_wdata),
        .rdata (instr_rdata)
    );

    mips_ram_bank #(
        .WORDS (DATA_WORDS)
    ) u_data_bank (
        .clk   (clk),
        .we    (data_we),
        .be    (lat_be),
        .idx   (data_idx),
        .wdata (lat_wdata),
        .rdata (data_rdata)
    );

`ifdef BUS_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && state == ACK) begin
            $display("%0t %s addr=%h be=%b data=%h%s", $time, lat_write ? "W" : "R",
                     {lat_word, 2'b00}, lat_be, lat_write ? lat_wdata : readdata,
                     lat_err ? " ERROR" : "");
        end
    end
`else
`endif

endmodule
